// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the fetch/data memory arbiter:
//   - arbiter state encodings (ARB_IDLE, ARB_IF_ACC, ARB_D_ACC)
//   - grant encodings used for round-robin history (GNT_IF, GNT_D)
//   - full byte-enable constant BE_ALL (sliced to the bus width by users)
//   - timer_width(): counter width needed for a given watchdog limit
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IF_ACC = 2'd1,
    ARB_D_ACC  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } arb_gnt_e;

  // Wide enough for any data bus up to 512 bits; users take the low BE_W bits.
  localparam int BE_MAX_W = 64;
  localparam logic [BE_MAX_W-1:0] BE_ALL = {BE_MAX_W{1'b1}};

  // Counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
  function automatic int timer_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// arb_timer
// Watchdog counter for one memory access. Counts cycles while en is high,
// saturating at TIMEOUT-1; clr has priority and returns the count to 0.
// Ports:
//   clk      in   clock, rising edge
//   rest     in   synchronous active-low reset
//   clr      in   clear count to 0
//   en       in   count this cycle (access in progress)
//   expired  out  count has reached TIMEOUT-1 during an enabled cycle
// TIMEOUT = 0 disables the watchdog (expired is never asserted).
module arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rest,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = timer_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : CNT_ZERO;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment until the last value is held.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_ZERO;
    end else if (en && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rest) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one req/ack memory port between the instruction-fetch path and the
// data (load/store) path. One transaction outstanding at a time, round-robin
// on contention, watchdog abort when mem_ack never arrives.
// Ports:
//   clk, rest                       clock, synchronous active-low reset
//   if_req/if_addr                  fetch request, held until if_done
//   if_rdata/if_done                fetched word and one-cycle completion
//   d_req/d_we/d_be/d_addr/d_wdata  data request, held until d_done
//   d_rdata/d_done                  read data and one-cycle completion
//   mem_req/we/be/addr/wdata        registered memory request, held for the access
//   mem_rdata/mem_ack               memory response, one cycle
//   busy                            an access is in progress
//   err                             pulses with done when the watchdog aborted
// All outputs are registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rest,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                busy,
  output logic                err
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_FULL = BE_ALL[BE_W-1:0];

  arb_state_e state_q, state_d;
  arb_gnt_e   last_gnt_q, last_gnt_d;

  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [BE_W-1:0]   mem_be_q,    mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
  logic              if_done_q,   if_done_d;
  logic              d_done_q,    d_done_d;
  logic              err_q,       err_d;
  logic              busy_q,      busy_d;

  logic if_elig_s;
  logic d_elig_s;
  logic acc_s;
  logic expired_s;
  logic end_s;
  logic timer_clr_s;

  // A request held high during its own done cycle is stale, not a new one.
  assign if_elig_s   = if_req && !if_done_q;
  assign d_elig_s    = d_req && !d_done_q;
  assign acc_s       = (state_q == ARB_IF_ACC) || (state_q == ARB_D_ACC);
  // Ack and expiry both end the access; ack takes precedence below.
  assign end_s       = acc_s && (mem_ack || expired_s);
  assign timer_clr_s = !acc_s || end_s;

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rest    (rest),
    .clr     (timer_clr_s),
    .en      (acc_s),
    .expired (expired_s)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rest) begin
      state_q     <= ARB_IDLE;
      last_gnt_q  <= GNT_D;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= {BE_W{1'b0}};
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      if_rdata_q  <= {DATA_W{1'b0}};
      d_rdata_q   <= {DATA_W{1'b0}};
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // Next state: round-robin grant in IDLE, leave an access on ack or expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (if_elig_s && (!d_elig_s || (last_gnt_q == GNT_D))) begin
          state_d = ARB_IF_ACC;
        end else if (d_elig_s) begin
          state_d = ARB_D_ACC;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_IF_ACC, ARB_D_ACC: begin
        if (end_s) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output values: latch the winner at grant, complete or abort at the end.
  always_comb begin
    last_gnt_d  = last_gnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    busy_d      = (state_d != ARB_IDLE);
    case (state_q)
      ARB_IDLE: begin
        if (state_d == ARB_IF_ACC) begin
          last_gnt_d = GNT_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_be_d   = BE_FULL;
          mem_addr_d = if_addr;
        end else if (state_d == ARB_D_ACC) begin
          last_gnt_d  = GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_be_d    = d_be;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else begin
          mem_req_d = 1'b0;
        end
      end
      ARB_IF_ACC, ARB_D_ACC: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == ARB_IF_ACC) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_done_d = 1'b1;
            // Writes leave the last read data in place.
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else if (expired_s) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          if (state_q == ARB_IF_ACC) begin
            if_done_d = 1'b1;
          end else begin
            d_done_d = 1'b1;
          end
        end else begin
          mem_req_d = mem_req_q;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with TIMEOUT=4. Inputs change and outputs
// are checked 1 time unit after each rising edge; every expected value is
// hand-derived from the arbiter's cycle timing.
module tb_mem_arbiter;

  logic        clk;
  logic        rest;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rest      (rest),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rest = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_rdata = 32'h0; mem_ack = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_mem_req", mem_req, 64'd0);
    chk("rst_busy", busy, 64'd0);
    chk("rst_if_done", if_done, 64'd0);
    chk("rst_d_done", d_done, 64'd0);
    chk("rst_err", err, 64'd0);
    chk("rst_mem_be", mem_be, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_if_rdata", if_rdata, 64'd0);

    // Simultaneous requests after reset: IF, D, IF, D
    rest = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0080;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0200;
    tick();
    chk("alt1_mem_req", mem_req, 64'd1);
    chk("alt1_addr_if", mem_addr, 64'h80);
    chk("alt1_busy", busy, 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    chk("alt1_if_done", if_done, 64'd1);
    chk("alt1_if_rdata", if_rdata, 64'h1111_1111);
    chk("alt1_mem_req_low", mem_req, 64'd0);
    tick();
    chk("alt2_addr_d", mem_addr, 64'h200);
    chk("alt2_mem_req", mem_req, 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    chk("alt2_d_done", d_done, 64'd1);
    chk("alt2_d_rdata", d_rdata, 64'h2222_2222);
    tick();
    chk("alt3_addr_if", mem_addr, 64'h80);
    mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
    tick();
    mem_ack = 1'b0;
    chk("alt3_if_rdata", if_rdata, 64'h3333_3333);
    tick();
    chk("alt4_addr_d", mem_addr, 64'h200);
    mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
    tick();
    mem_ack = 1'b0;
    chk("alt4_d_done", d_done, 64'd1);
    chk("alt4_d_rdata", d_rdata, 64'h4444_4444);
    if_req = 1'b0; d_req = 1'b0;
    tick();
    chk("alt_idle_busy", busy, 64'd0);

    // Single fetch, ack in cycle 3
    if_req = 1'b1; if_addr = 32'h0000_0040;
    tick();
    chk("sf_c1_mem_req", mem_req, 64'd1);
    chk("sf_c1_mem_we", mem_we, 64'd0);
    chk("sf_c1_mem_be", mem_be, 64'hF);
    chk("sf_c1_mem_addr", mem_addr, 64'h40);
    tick();
    chk("sf_c2_mem_req", mem_req, 64'd1);
    tick();
    chk("sf_c3_mem_req", mem_req, 64'd1);
    chk("sf_c3_if_done", if_done, 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
    tick();
    mem_ack = 1'b0;
    chk("sf_c4_if_done", if_done, 64'd1);
    chk("sf_c4_if_rdata", if_rdata, 64'h2008_0005);
    chk("sf_c4_err", err, 64'd0);
    chk("sf_c4_mem_req", mem_req, 64'd0);
    if_req = 1'b0;
    tick();
    chk("sf_c5_if_done", if_done, 64'd0);
    chk("sf_c5_busy", busy, 64'd0);

    // Tie after a fetch grant: data wins; write with latched inputs
    if_req = 1'b1; if_addr = 32'h0000_0044;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h0000_0100; d_wdata = 32'hAABB_CCDD;
    tick();
    chk("wr_mem_we", mem_we, 64'd1);
    chk("wr_mem_be", mem_be, 64'h3);
    chk("wr_mem_addr", mem_addr, 64'h100);
    chk("wr_mem_wdata", mem_wdata, 64'hAABB_CCDD);
    d_addr = 32'h0000_0999; d_wdata = 32'h0;
    tick();
    chk("wr_latched_addr", mem_addr, 64'h100);
    chk("wr_latched_wdata", mem_wdata, 64'hAABB_CCDD);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("wr_d_done", d_done, 64'd1);
    chk("wr_d_rdata_kept", d_rdata, 64'h4444_4444);
    chk("wr_mem_we_low", mem_we, 64'd0);
    chk("wr_err", err, 64'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("wr_next_if_addr", mem_addr, 64'h44);
    chk("wr_next_if_be", mem_be, 64'hF);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    chk("wr_next_if_rdata", if_rdata, 64'h5555_5555);
    if_req = 1'b0;
    tick();
    chk("wr_idle_busy", busy, 64'd0);

    // Spurious ack in IDLE, then a read that times out
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    d_req = 1'b1; d_be = 4'hF; d_addr = 32'h0000_0300;
    tick();
    mem_ack = 1'b0;
    chk("to_c1_mem_req", mem_req, 64'd1);
    chk("spur_d_done", d_done, 64'd0);
    tick();
    tick();
    tick();
    chk("to_c4_mem_req", mem_req, 64'd1);
    chk("to_c4_err", err, 64'd0);
    tick();
    chk("to_c5_mem_req", mem_req, 64'd0);
    chk("to_c5_d_done", d_done, 64'd1);
    chk("to_c5_err", err, 64'd1);
    chk("to_c5_d_rdata", d_rdata, 64'h4444_4444);
    chk("to_c5_busy", busy, 64'd0);
    d_req = 1'b0;
    tick();
    chk("to_c6_busy", busy, 64'd0);
    chk("to_c6_err", err, 64'd0);

    // Ack in the expiry cycle wins
    d_req = 1'b1; d_addr = 32'h0000_0304;
    tick(); tick(); tick(); tick();
    chk("ex_c4_mem_req", mem_req, 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'h6666_6666;
    tick();
    mem_ack = 1'b0;
    chk("ex_d_done", d_done, 64'd1);
    chk("ex_err", err, 64'd0);
    chk("ex_d_rdata", d_rdata, 64'h6666_6666);
    d_req = 1'b0;
    tick();

    // Reset in the second D_ACC cycle, then pending fetch wins
    d_req = 1'b1; d_addr = 32'h0000_0308;
    tick();
    chk("rm_c1_mem_req", mem_req, 64'd1);
    tick();
    rest = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0048;
    tick();
    chk("rm_mem_req", mem_req, 64'd0);
    chk("rm_busy", busy, 64'd0);
    chk("rm_d_done", d_done, 64'd0);
    chk("rm_err", err, 64'd0);
    rest = 1'b1;
    tick();
    chk("rm_regrant_req", mem_req, 64'd1);
    chk("rm_regrant_addr", mem_addr, 64'h48);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    chk("rm_if_done", if_done, 64'd1);
    chk("rm_d_done_after", d_done, 64'd0);
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
